// File: rtl/uart_display_receiver.sv
// uart_display_receiver
// UART receive front-end for the display path: 8 data bits LSB-first, even
// parity, one stop bit, 16x oversampling. Consecutive good bytes are paired
// into a 16-bit word {first, second} that is held on signal_to_display.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | line idle, waiting for a falling edge (after break hold-off)
// START  | validating start bit at its mid-point (sample 7)
// DATA   | sampling 8 data bits at sample 15 of each bit period
// PARITY | sampling the parity bit, latching the parity check result
// STOP   | sampling the stop bit; byte is evaluated at this point
module uart_display_receiver #(
    parameter int unsigned BAUD_DIV     = 16,
    parameter int unsigned TIMEOUT_BITS = 32,
    parameter logic [15:0] RESET_WORD   = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_data,
    output logic [15:0] signal_to_display,
    output logic        word_valid,
    output logic        parity_error,
    output logic        frame_error,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam int unsigned TO_TICKS  = 16 * TIMEOUT_BITS;
    localparam int unsigned TO_W      = $clog2(TO_TICKS + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_TICKS - 1);

    // synchronizer
    logic            r_rx_meta;
    logic            r_rx_s;

    // oversample tick
    logic [15:0]     r_baud_cnt;
    logic            w_tick;

    // FSM
    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_start_go;
    logic            w_to_data;
    logic            w_shift;
    logic            w_perr_latch;
    logic            w_byte_done;
    logic            w_mid;

    // bit datapath
    logic [3:0]      r_sample_cnt;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_shreg;
    logic            r_perr;
    logic            r_armed;

    // byte evaluation
    logic            w_frame_bad;
    logic            w_par_bad;
    logic            w_good;

    // word assembly and timeout
    logic            r_byte_idx;
    logic [7:0]      r_hi_reg;
    logic [TO_W-1:0] r_to_cnt;
    logic            w_to_expire;

    // registered outputs
    logic [15:0]     r_word;
    logic            r_word_valid;
    logic            r_parity_error;
    logic            r_frame_error;
    logic            r_busy;

    assign w_tick = (r_baud_cnt == BAUD_LAST);
    assign w_mid  = w_tick && (r_sample_cnt == 4'd15);

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx_data;
            r_rx_s    <= r_rx_meta;
        end
    end

    // Free-running oversample divider, one-cycle tick on the last count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_baud_cnt <= 16'd0;
        end else if (w_tick) begin
            r_baud_cnt <= 16'd0;
        end else begin
            r_baud_cnt <= r_baud_cnt + 16'd1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and datapath strobes; every transition happens on a tick.
    always_comb begin
        w_state_nxt  = r_state;
        w_start_go   = 1'b0;
        w_to_data    = 1'b0;
        w_shift      = 1'b0;
        w_perr_latch = 1'b0;
        w_byte_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                // r_armed blocks a held-low line from restarting after a bad stop
                if (w_tick && !r_rx_s && r_armed) begin
                    w_state_nxt = S_START;
                    w_start_go  = 1'b1;
                end
            end
            S_START: begin
                if (w_tick && (r_sample_cnt == 4'd7)) begin
                    if (r_rx_s) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_DATA;
                        w_to_data   = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (w_mid) begin
                    w_shift = 1'b1;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_nxt = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                if (w_mid) begin
                    w_perr_latch = 1'b1;
                    w_state_nxt  = S_STOP;
                end
            end
            S_STOP: begin
                if (w_mid) begin
                    w_byte_done = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // A low stop bit wins over a parity failure; only one verdict per byte.
    assign w_frame_bad = w_byte_done && !r_rx_s;
    assign w_par_bad   = w_byte_done &&  r_rx_s &&  r_perr;
    assign w_good      = w_byte_done &&  r_rx_s && !r_perr;

    // A start detection in the same tick takes precedence over expiry.
    assign w_to_expire = w_tick && (r_state == S_IDLE) && r_byte_idx &&
                         !w_start_go && (r_to_cnt == TO_LAST);

    // Oversample position within the current bit; parked at 0 while idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sample_cnt <= 4'd0;
        end else if (w_tick) begin
            if (w_start_go || w_to_data || (w_state_nxt == S_IDLE)) begin
                r_sample_cnt <= 4'd0;
            end else begin
                r_sample_cnt <= r_sample_cnt + 4'd1;
            end
        end
    end

    // Data bit counter, shift register (LSB arrives first) and parity check.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bit_cnt <= 3'd0;
            r_shreg   <= 8'h00;
            r_perr    <= 1'b0;
        end else begin
            if (w_to_data) begin
                r_bit_cnt <= 3'd0;
            end else if (w_shift) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (w_shift) begin
                r_shreg <= {r_rx_s, r_shreg[7:1]};
            end
            if (w_perr_latch) begin
                r_perr <= r_rx_s ^ (^r_shreg);
            end
        end
    end

    // Break hold-off: after a framing error a high tick is needed before re-arming.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_armed <= 1'b1;
        end else if (w_frame_bad) begin
            r_armed <= 1'b0;
        end else if (w_tick && (r_state == S_IDLE) && r_rx_s) begin
            r_armed <= 1'b1;
        end
    end

    // Byte pairing: first good byte parks in r_hi_reg, errors or timeout drop it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_byte_idx <= 1'b0;
            r_hi_reg   <= 8'h00;
        end else if (w_frame_bad || w_par_bad) begin
            r_byte_idx <= 1'b0;
        end else if (w_good) begin
            if (!r_byte_idx) begin
                r_hi_reg   <= r_shreg;
                r_byte_idx <= 1'b1;
            end else begin
                r_byte_idx <= 1'b0;
            end
        end else if (w_to_expire) begin
            r_byte_idx <= 1'b0;
        end
    end

    // Inter-byte timeout: counts idle ticks while a high byte is pending.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_to_cnt <= '0;
        end else if (w_good || w_start_go) begin
            r_to_cnt <= '0;
        end else if (w_tick && (r_state == S_IDLE) && r_byte_idx) begin
            if (w_to_expire) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end

    // Registered outputs: word update with its strobe, error pulses, busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_word         <= RESET_WORD;
            r_word_valid   <= 1'b0;
            r_parity_error <= 1'b0;
            r_frame_error  <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_word_valid   <= w_good && r_byte_idx;
            r_parity_error <= w_par_bad;
            r_frame_error  <= w_frame_bad;
            r_busy         <= (w_state_nxt != S_IDLE);
            if (w_good && r_byte_idx) begin
                r_word <= {r_hi_reg, r_shreg};
            end
        end
    end

    assign signal_to_display = r_word;
    assign word_valid        = r_word_valid;
    assign parity_error      = r_parity_error;
    assign frame_error       = r_frame_error;
    assign busy              = r_busy;

endmodule

// File: tb/tb_uart_display_receiver.sv
// Testbench for uart_display_receiver: table of frames with expected pulse
// counts and displayed word, plus hand-written glitch and mid-frame reset runs.
module tb_uart_display_receiver;

    localparam int          BAUD_DIV     = 4;
    localparam int          TIMEOUT_BITS = 4;
    localparam logic [15:0] RESET_WORD   = 16'hC0DE;
    localparam int          BIT_CLKS     = 16 * BAUD_DIV;

    logic        clk     = 1'b0;
    logic        reset   = 1'b1;
    logic        rx_data = 1'b1;
    logic [15:0] signal_to_display;
    logic        word_valid;
    logic        parity_error;
    logic        frame_error;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    int          n_valid   = 0;
    int          n_perr    = 0;
    int          n_ferr    = 0;
    int          n_multi   = 0;
    int          n_busy    = 0;
    int          n_bad_upd = 0;
    logic [15:0] prev_word = 16'h0000;

    typedef struct {
        logic [7:0]  data;
        bit          bad_par;
        bit          bad_stop;
        int          hold_low;
        int          idle;
        int          exp_valid;
        int          exp_perr;
        int          exp_ferr;
        logic [15:0] exp_word;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs[NVEC];

    always #5 clk = ~clk;

    uart_display_receiver #(
        .BAUD_DIV    (BAUD_DIV),
        .TIMEOUT_BITS(TIMEOUT_BITS),
        .RESET_WORD  (RESET_WORD)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .rx_data          (rx_data),
        .signal_to_display(signal_to_display),
        .word_valid       (word_valid),
        .parity_error     (parity_error),
        .frame_error      (frame_error),
        .busy             (busy)
    );

    // Output monitor: pulse/busy cycle counts, overlap and unannounced word changes.
    always @(negedge clk) begin
        if (!reset) begin
            if (word_valid) n_valid++;
            else if (signal_to_display !== prev_word) n_bad_upd++;
            if (parity_error) n_perr++;
            if (frame_error) n_ferr++;
            if ((32'(word_valid) + 32'(parity_error) + 32'(frame_error)) > 1) n_multi++;
            if (busy) n_busy++;
        end
        prev_word = signal_to_display;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached, errors so far %0d", n_errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic v);
        rx_data = v;
        repeat (BIT_CLKS) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bp, input bit bs,
                              input int hold_low, input int idle);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit((^d) ^ bp);
        send_bit(~bs);
        repeat (hold_low) send_bit(1'b0);
        repeat (idle) send_bit(1'b1);
    endtask

    function automatic vec_t mk(input logic [7:0] d, input bit bp, input bit bs,
                                input int hl, input int idl, input int ev,
                                input int ep, input int ef, input logic [15:0] w);
        vec_t v;
        v.data = d; v.bad_par = bp; v.bad_stop = bs; v.hold_low = hl; v.idle = idl;
        v.exp_valid = ev; v.exp_perr = ep; v.exp_ferr = ef; v.exp_word = w;
        return v;
    endfunction

    initial begin
        int          v0, p0, f0, b0;
        logic [15:0] exp_disp;

        //             data   bp  bs  hold idle val per fer word
        vecs[0]  = mk(8'h12, 0,  0,  0,   2,   0,  0,  0,  16'h0000);
        vecs[1]  = mk(8'h34, 0,  0,  0,   2,   1,  0,  0,  16'h1234);
        vecs[2]  = mk(8'h12, 1,  0,  0,   1,   0,  1,  0,  16'h0000);
        vecs[3]  = mk(8'h34, 0,  0,  0,   1,   0,  0,  0,  16'h0000);
        vecs[4]  = mk(8'h56, 0,  0,  0,   2,   1,  0,  0,  16'h3456);
        vecs[5]  = mk(8'hAB, 1,  1,  20,  2,   0,  0,  1,  16'h0000);
        vecs[6]  = mk(8'h00, 0,  0,  0,   1,   0,  0,  0,  16'h0000);
        vecs[7]  = mk(8'hFF, 0,  0,  0,   2,   1,  0,  0,  16'h00FF);
        vecs[8]  = mk(8'h11, 0,  0,  0,   5,   0,  0,  0,  16'h0000);
        vecs[9]  = mk(8'h22, 0,  0,  0,   1,   0,  0,  0,  16'h0000);
        vecs[10] = mk(8'h33, 0,  0,  0,   2,   1,  0,  0,  16'h2233);
        vecs[11] = mk(8'h44, 0,  0,  0,   3,   0,  0,  0,  16'h0000);
        vecs[12] = mk(8'h55, 0,  0,  0,   2,   1,  0,  0,  16'h4455);
        vecs[13] = mk(8'h66, 0,  0,  0,   1,   0,  0,  0,  16'h0000);
        vecs[14] = mk(8'h77, 1,  0,  0,   1,   0,  1,  0,  16'h0000);
        vecs[15] = mk(8'h88, 0,  0,  0,   1,   0,  0,  0,  16'h0000);
        vecs[16] = mk(8'h99, 0,  0,  0,   2,   1,  0,  0,  16'h8899);

        repeat (5) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset word", 32'(signal_to_display), 32'(RESET_WORD));
        check("reset word_valid", 32'(word_valid), 0);
        check("reset parity_error", 32'(parity_error), 0);
        check("reset frame_error", 32'(frame_error), 0);
        check("reset busy", 32'(busy), 0);
        exp_disp = RESET_WORD;

        @(posedge clk);
        #1;
        repeat (2) send_bit(1'b1);

        for (int i = 0; i < NVEC; i++) begin
            v0 = n_valid; p0 = n_perr; f0 = n_ferr;
            send_frame(vecs[i].data, vecs[i].bad_par, vecs[i].bad_stop,
                       vecs[i].hold_low, vecs[i].idle);
            @(negedge clk);
            if (vecs[i].exp_valid != 0) exp_disp = vecs[i].exp_word;
            check($sformatf("vec%0d word_valid count", i), 32'(n_valid - v0), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d parity_error count", i), 32'(n_perr - p0), 32'(vecs[i].exp_perr));
            check($sformatf("vec%0d frame_error count", i), 32'(n_ferr - f0), 32'(vecs[i].exp_ferr));
            check($sformatf("vec%0d display", i), 32'(signal_to_display), 32'(exp_disp));
            check($sformatf("vec%0d busy idle", i), 32'(busy), 0);
            @(posedge clk);
            #1;
        end

        // Glitch shorter than half a bit: FSM leaves IDLE, then returns silently.
        v0 = n_valid; p0 = n_perr; f0 = n_ferr; b0 = n_busy;
        rx_data = 1'b0;
        repeat (5 * BAUD_DIV) @(posedge clk);
        #1;
        rx_data = 1'b1;
        repeat (2) send_bit(1'b1);
        @(negedge clk);
        check("glitch busy seen", 32'(n_busy > b0), 1);
        check("glitch busy idle", 32'(busy), 0);
        check("glitch pulses", 32'((n_valid - v0) + (n_perr - p0) + (n_ferr - f0)), 0);
        check("glitch display", 32'(signal_to_display), 32'(exp_disp));
        @(posedge clk);
        #1;
        v0 = n_valid;
        send_frame(8'h9C, 0, 0, 0, 1);
        send_frame(8'h01, 0, 0, 0, 2);
        @(negedge clk);
        check("glitch follow-up valid", 32'(n_valid - v0), 1);
        check("glitch follow-up word", 32'(signal_to_display), 32'h9C01);

        // Reset mid-DATA of the second byte after a displayed word.
        @(posedge clk);
        #1;
        send_frame(8'h12, 0, 0, 0, 1);
        send_frame(8'h34, 0, 0, 0, 2);
        @(negedge clk);
        check("pre-reset word", 32'(signal_to_display), 32'h1234);
        @(posedge clk);
        #1;
        send_frame(8'h5F, 0, 0, 0, 1);
        v0 = n_valid; p0 = n_perr; f0 = n_ferr;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        @(negedge clk);
        check("mid-frame busy", 32'(busy), 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("async reset word", 32'(signal_to_display), 32'(RESET_WORD));
        check("async reset busy", 32'(busy), 0);
        check("async reset word_valid", 32'(word_valid), 0);
        rx_data = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) send_bit(1'b1);
        @(negedge clk);
        check("reset pulses", 32'((n_valid - v0) + (n_perr - p0) + (n_ferr - f0)), 0);
        check("post-reset display", 32'(signal_to_display), 32'(RESET_WORD));
        @(posedge clk);
        #1;
        v0 = n_valid;
        send_frame(8'h5A, 0, 0, 0, 1);
        send_frame(8'hA5, 0, 0, 0, 2);
        @(negedge clk);
        check("post-reset valid", 32'(n_valid - v0), 1);
        check("post-reset word", 32'(signal_to_display), 32'h5AA5);

        check("pulse overlap cycles", 32'(n_multi), 0);
        check("word change without valid", 32'(n_bad_upd), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
